// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared helpers for the core datapath blocks. GetWidth gives
//               the pointer width needed to address a storage of n entries.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  // Address width for n entries; a single-entry storage still gets one bit
  function automatic int unsigned GetWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ordered_read_slot.sv
`default_nettype none
// ============================================================================
// Module      : ordered_read_slot
// Description : One consumer port of the ordered read controller. Holds the
//               output register (valid/data/tag) and the per-port sequence
//               counter, and decides when this port pops its FIFO read port.
// Revision    : 1.0 - initial release
// ============================================================================
module ordered_read_slot #(
  parameter type         dtype   = logic [31:0],
  parameter int unsigned IdWidth = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               empty_i,
  input  logic               order_ok_i,
  input  dtype               data_i,
  input  logic               ready_i,
  output logic               pop_o,
  output logic               valid_o,
  output dtype               data_o,
  output logic [IdWidth-1:0] id_o
);

  logic               load;
  logic               valid_q, valid_d;
  logic [IdWidth-1:0] seq_q, seq_d;
  logic [IdWidth-1:0] id_q, id_d;
  dtype               data_q, data_d;

  // Load when an entry is available, ordering allows it and the output
  // register is free or draining this cycle; flush wins over everything
  always_comb begin
    load    = ~flush_i & ~empty_i & order_ok_i & (~valid_q | ready_i);
    valid_d = valid_q;
    seq_d   = seq_q;
    id_d    = id_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      seq_d   = '0;
    end else if (load) begin
      valid_d = 1'b1;
      seq_d   = seq_q + IdWidth'(1);
      id_d    = seq_q;
      data_d  = data_i;
    end else if (valid_q & ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      seq_q   <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      seq_q   <= seq_d;
      id_q    <= id_d;
    end
  end

  // Payload register carries no reset; it is only meaningful while valid
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign pop_o   = load;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign id_o    = id_q;

endmodule
`default_nettype wire

// File: rtl/ordered_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ordered_read_ctrl
// Description : Converts the read ports of a shared multi-read-port FIFO into
//               registered valid/ready streams tagged with a sequence ID,
//               while guaranteeing port i never pops an entry before port i-1.
// Revision    : 1.0 - initial release
// ============================================================================
module ordered_read_ctrl
  import core_pkg::*;
#(
  parameter int unsigned NrPort    = 2,
  parameter int unsigned Depth     = 8,
  parameter int unsigned DataWidth = 32,
  parameter type         dtype     = logic [DataWidth-1:0],
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned AddrDepth = GetWidth(Depth),
  parameter type         cnt_t     = logic [AddrDepth:0]
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic [NrPort-1:0]  fifo_empty_i,
  input  cnt_t               fifo_usage_i [NrPort],
  input  dtype               fifo_data_i  [NrPort],
  output logic [NrPort-1:0]  fifo_pop_o,
  output logic [NrPort-1:0]  valid_o,
  input  logic [NrPort-1:0]  ready_i,
  output dtype               data_o       [NrPort],
  output logic [IdWidth-1:0] id_o         [NrPort],
  output logic               idle_o
);

  logic [NrPort-1:0] order_ok;

  for (genvar i = 0; i < NrPort; i++) begin : g_port
    // A downstream port may only pop while it still holds more entries than
    // its predecessor, i.e. the predecessor has already consumed the head.
    // Only the FIFO's registered counts are used, never this cycle's pops.
    if (i == 0) begin : g_first
      assign order_ok[i] = 1'b1;
    end else begin : g_rest
      assign order_ok[i] = fifo_usage_i[i] > fifo_usage_i[i-1];
    end

    ordered_read_slot #(
      .dtype  (dtype),
      .IdWidth(IdWidth)
    ) u_slot (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .flush_i   (flush_i),
      .empty_i   (fifo_empty_i[i]),
      .order_ok_i(order_ok[i]),
      .data_i    (fifo_data_i[i]),
      .ready_i   (ready_i[i]),
      .pop_o     (fifo_pop_o[i]),
      .valid_o   (valid_o[i]),
      .data_o    (data_o[i]),
      .id_o      (id_o[i])
    );
  end

  assign idle_o = ~|valid_o & &fifo_empty_i;

endmodule
`default_nettype wire

// File: tb/tb_ordered_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ordered_read_ctrl
// Description : Directed bench for ordered_read_ctrl (2 ports, depth 8,
//               2-bit tags) driven by a small shared-FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ordered_read_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       flush_i;
  logic [1:0] fifo_empty_i;
  logic [3:0] fifo_usage_i [2];
  logic [7:0] fifo_data_i  [2];
  logic [1:0] fifo_pop_o;
  logic [1:0] valid_o;
  logic [1:0] ready_i;
  logic [7:0] data_o       [2];
  logic [1:0] id_o         [2];
  logic       idle_o;

  int n_cmp = 0;
  int n_err = 0;

  // FIFO model: shared storage, one write pointer, one read pointer per port
  logic [7:0] mem [16];
  int         wr;
  int         rd [2];

  always #5 clk = ~clk;

  ordered_read_ctrl #(
    .NrPort   (2),
    .Depth    (8),
    .DataWidth(8),
    .dtype    (logic [7:0]),
    .IdWidth  (2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_usage_i(fifo_usage_i),
    .fifo_data_i (fifo_data_i),
    .fifo_pop_o  (fifo_pop_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .id_o        (id_o),
    .idle_o      (idle_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      int u;
      u = wr - rd[i];
      fifo_usage_i[i] = 4'(u);
      fifo_empty_i[i] = (u == 0);
      fifo_data_i[i]  = mem[rd[i] % 16];
    end
    #1;
  endtask

  task automatic push(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      mem[wr % 16] = base + 8'(k);
      wr++;
    end
    drive();
  endtask

  // Advance one clock; the FIFO model consumes the pops the DUT issued
  task automatic tick();
    logic [1:0] p;
    logic       fl;
    chk("pop_on_empty", 32'(fifo_pop_o & fifo_empty_i), 32'd0);
    chk("usage_order", 32'(fifo_usage_i[1] >= fifo_usage_i[0]), 32'd1);
    p  = fifo_pop_o;
    fl = flush_i;
    @(posedge clk);
    #1;
    if (fl) begin
      wr    = 0;
      rd[0] = 0;
      rd[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++) if (p[i]) rd[i]++;
    end
    drive();
  endtask

  task automatic expect_st(input string tag, input logic [1:0] e_pop, input logic [1:0] e_val,
                           input logic [7:0] d0, input logic [1:0] i0,
                           input logic [7:0] d1, input logic [1:0] i1);
    chk({tag, ".pop"},   32'(fifo_pop_o), 32'(e_pop));
    chk({tag, ".valid"}, 32'(valid_o),    32'(e_val));
    if (e_val[0]) begin
      chk({tag, ".data0"}, 32'(data_o[0]), 32'(d0));
      chk({tag, ".id0"},   32'(id_o[0]),   32'(i0));
    end
    if (e_val[1]) begin
      chk({tag, ".data1"}, 32'(data_o[1]), 32'(d1));
      chk({tag, ".id1"},   32'(id_o[1]),   32'(i1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    ready_i = 2'b00;
    wr      = 0;
    rd[0]   = 0;
    rd[1]   = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(valid_o), 32'd0);
    chk("rst.id0",   32'(id_o[0]), 32'd0);
    chk("rst.id1",   32'(id_o[1]), 32'd0);
    chk("rst.idle",  32'(idle_o),  32'd1);
    chk("rst.pop",   32'(fifo_pop_o), 32'd0);
    rst_ni = 1'b1;
    #1;

    // Drain of 6 entries, both consumers ready: port 1 lags by one cycle, tags wrap at 4
    ready_i = 2'b11;
    push(6, 8'h10);
    expect_st("s1c0", 2'b01, 2'b00, 8'h00, 2'd0, 8'h00, 2'd0); tick();
    expect_st("s1c1", 2'b11, 2'b01, 8'h10, 2'd0, 8'h00, 2'd0); tick();
    expect_st("s1c2", 2'b11, 2'b11, 8'h11, 2'd1, 8'h10, 2'd0); tick();
    expect_st("s1c3", 2'b11, 2'b11, 8'h12, 2'd2, 8'h11, 2'd1); tick();
    expect_st("s1c4", 2'b11, 2'b11, 8'h13, 2'd3, 8'h12, 2'd2); tick();
    expect_st("s1c5", 2'b11, 2'b11, 8'h14, 2'd0, 8'h13, 2'd3); tick();
    expect_st("s1c6", 2'b10, 2'b11, 8'h15, 2'd1, 8'h14, 2'd0); tick();
    expect_st("s1c7", 2'b00, 2'b10, 8'h00, 2'd0, 8'h15, 2'd1);
    chk("s1c7.idle", 32'(idle_o), 32'd0);
    tick();
    expect_st("s1c8", 2'b00, 2'b00, 8'h00, 2'd0, 8'h00, 2'd0);
    chk("s1c8.idle", 32'(idle_o), 32'd1);

    // Backpressure on port 0: port 1 takes exactly one entry, then stalls
    ready_i = 2'b10;
    push(4, 8'h20);
    expect_st("s2c0", 2'b01, 2'b00, 8'h00, 2'd0, 8'h00, 2'd0); tick();
    expect_st("s2c1", 2'b10, 2'b01, 8'h20, 2'd2, 8'h00, 2'd0); tick();
    expect_st("s2c2", 2'b00, 2'b11, 8'h20, 2'd2, 8'h20, 2'd2); tick();
    expect_st("s2c3", 2'b00, 2'b01, 8'h20, 2'd2, 8'h00, 2'd0);
    ready_i = 2'b11;
    #1;
    expect_st("s2c3r", 2'b01, 2'b01, 8'h20, 2'd2, 8'h00, 2'd0); tick();
    expect_st("s2c4", 2'b11, 2'b01, 8'h21, 2'd3, 8'h00, 2'd0); tick();
    expect_st("s2c5", 2'b11, 2'b11, 8'h22, 2'd0, 8'h21, 2'd3); tick();
    expect_st("s2c6", 2'b10, 2'b11, 8'h23, 2'd1, 8'h22, 2'd0); tick();
    expect_st("s2c7", 2'b00, 2'b10, 8'h00, 2'd0, 8'h23, 2'd1); tick();
    expect_st("s2c8", 2'b00, 2'b00, 8'h00, 2'd0, 8'h00, 2'd0);

    // Full FIFO: usage 8 vs 8 blocks port 1, 7 vs 8 releases it
    push(8, 8'h30);
    expect_st("s3c0", 2'b01, 2'b00, 8'h00, 2'd0, 8'h00, 2'd0); tick();
    expect_st("s3c1", 2'b11, 2'b01, 8'h30, 2'd2, 8'h00, 2'd0); tick();
    expect_st("s3c2", 2'b11, 2'b11, 8'h31, 2'd3, 8'h30, 2'd2);
    for (int k = 0; k < 20 && !idle_o; k++) tick();
    chk("s3.idle", 32'(idle_o), 32'd1);

    // Flush with two valid outputs and entries still in the FIFO
    ready_i = 2'b00;
    push(5, 8'h40);
    expect_st("s4c0", 2'b01, 2'b00, 8'h00, 2'd0, 8'h00, 2'd0); tick();
    expect_st("s4c1", 2'b10, 2'b01, 8'h40, 2'd2, 8'h00, 2'd0); tick();
    expect_st("s4c2", 2'b00, 2'b11, 8'h40, 2'd2, 8'h40, 2'd2);
    ready_i = 2'b11;
    flush_i = 1'b1;
    #1;
    expect_st("s4fl", 2'b00, 2'b11, 8'h40, 2'd2, 8'h40, 2'd2);
    tick();
    flush_i = 1'b0;
    #1;
    expect_st("s4c3", 2'b00, 2'b00, 8'h00, 2'd0, 8'h00, 2'd0);
    chk("s4c3.idle", 32'(idle_o), 32'd1);
    push(1, 8'h50);
    expect_st("s4c3p", 2'b01, 2'b00, 8'h00, 2'd0, 8'h00, 2'd0); tick();
    expect_st("s4c4", 2'b10, 2'b01, 8'h50, 2'd0, 8'h00, 2'd0); tick();
    expect_st("s4c5", 2'b00, 2'b10, 8'h00, 2'd0, 8'h50, 2'd0); tick();

    // Asynchronous reset in the middle of a transfer
    ready_i = 2'b00;
    push(2, 8'h60);
    tick();
    chk("s5.valid_pre", 32'(valid_o[0]), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("s5.valid_rst", 32'(valid_o), 32'd0);
    chk("s5.id0_rst",   32'(id_o[0]), 32'd0);
    wr    = 0;
    rd[0] = 0;
    rd[1] = 0;
    drive();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    #1;
    chk("s5.idle", 32'(idle_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
